pipe_hazard_ctrl: RTL

Central stall/flush sequencer for the five-stage pipeline. It consumes hazard and status signals from ID, EX and both caches and drives the per-latch STALL and FLUSH inputs of the IF/ID, ID/EX and EX/MEM pipeline registers. It also drives the PC redirect select. It sits beside the datapath and is the single owner of every STALL/FLUSH net.

---
 rtl/pipe_ctrl_pkg.sv | 17 +
 rtl/pipe_hazard_ctrl_if.sv | 43 ++++
 rtl/pipe_hazard_ctrl_load_use_detect.sv | 16 +
 rtl/pipe_hazard_ctrl.sv | 128 ++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and defaults for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

    localparam int unsigned STATE_W          = 2;
    localparam int unsigned RCNT_W           = 3;
    localparam int unsigned REDIRECT_CYC_DEF = 2;
    localparam int unsigned CNT_W_DEF        = 32;
    localparam int unsigned REG_W_DEF        = 5;

    typedef enum logic [STATE_W-1:0] {
        RUN       = 2'd0,
        FETCHWAIT = 2'd1,
        REDIRECT  = 2'd2,
        MEMWAIT   = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard/status inputs and stall/flush/redirect outputs of the pipeline sequencer.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned CNT_W = pipe_ctrl_pkg::CNT_W_DEF,
    parameter int unsigned REG_W = pipe_ctrl_pkg::REG_W_DEF
);
    logic [REG_W-1:0]                 ID_Rs;
    logic [REG_W-1:0]                 ID_Rt;
    logic                             ID_UsesRs;
    logic                             ID_UsesRt;
    logic                             EX_MemRead;
    logic [REG_W-1:0]                 EX_Rd;
    logic                             EX_Mispredict;
    logic                             IC_Busy;
    logic                             DC_Busy;

    logic                             STALL_IF;
    logic                             STALL_ID;
    logic                             STALL_EX;
    logic                             STALL_MEM;
    logic                             FLUSH_ID;
    logic                             FLUSH_EX;
    logic                             Redirect_Valid;
    logic [pipe_ctrl_pkg::STATE_W-1:0] Ctrl_State;
    logic [CNT_W-1:0]                 Stall_Cycles;
    logic [CNT_W-1:0]                 Flush_Events;
    logic [CNT_W-1:0]                 LoadUse_Count;

    // Sequencer side
    modport master (
        input  ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, EX_MemRead, EX_Rd,
               EX_Mispredict, IC_Busy, DC_Busy,
        output STALL_IF, STALL_ID, STALL_EX, STALL_MEM, FLUSH_ID, FLUSH_EX,
               Redirect_Valid, Ctrl_State, Stall_Cycles, Flush_Events, LoadUse_Count
    );

    // Datapath side
    modport slave (
        output ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, EX_MemRead, EX_Rd,
               EX_Mispredict, IC_Busy, DC_Busy,
        input  STALL_IF, STALL_ID, STALL_EX, STALL_MEM, FLUSH_ID, FLUSH_EX,
               Redirect_Valid, Ctrl_State, Stall_Cycles, Flush_Events, LoadUse_Count
    );
endinterface

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Combinational load-use hazard comparator between the load in EX and the instruction in ID.
module load_use_detect #(
    parameter int unsigned REG_W = pipe_ctrl_pkg::REG_W_DEF
) (
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    output logic             hit_c
);
    // r0 is never a real dependency
    assign hit_c = ex_mem_read && (ex_rd != '0) &&
                   ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the five-stage pipeline.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REDIRECT_CYC = REDIRECT_CYC_DEF,
    parameter int unsigned CNT_W        = CNT_W_DEF,
    parameter int unsigned REG_W        = REG_W_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    pipe_hazard_ctrl_if.master bus
);

    ctrl_state_t       state, state_nxt, eff_c;
    logic [RCNT_W-1:0] rcnt, rcnt_nxt;
    logic              ctx_redirect, ctx_nxt;
    logic              lu_hit_c;
    logic              s_if_c, s_id_c, s_ex_c, s_mem_c, f_id_c, f_ex_c, rv_c;

    load_use_detect #(.REG_W(REG_W)) u_lu (
        .id_rs       (bus.ID_Rs),
        .id_rt       (bus.ID_Rt),
        .id_uses_rs  (bus.ID_UsesRs),
        .id_uses_rt  (bus.ID_UsesRt),
        .ex_mem_read (bus.EX_MemRead),
        .ex_rd       (bus.EX_Rd),
        .hit_c       (lu_hit_c)
    );

    // MEMWAIT behaves as the context it interrupted once DC_Busy drops
    assign eff_c = (state == MEMWAIT) ? (ctx_redirect ? REDIRECT : RUN) : state;

    // Priority-ordered hazard response and next-state selection
    always_comb begin
        state_nxt = eff_c;
        rcnt_nxt  = rcnt;
        ctx_nxt   = ctx_redirect;
        s_if_c    = 1'b0;
        s_id_c    = 1'b0;
        s_ex_c    = 1'b0;
        s_mem_c   = 1'b0;
        f_id_c    = 1'b0;
        f_ex_c    = 1'b0;
        rv_c      = 1'b0;
        if (bus.DC_Busy) begin
            {s_if_c, s_id_c, s_ex_c, s_mem_c} = 4'b1111;
            state_nxt = MEMWAIT;
            ctx_nxt   = (eff_c == REDIRECT);
        end else if (eff_c == REDIRECT) begin
            f_id_c = 1'b1;
            if (bus.IC_Busy) begin
                s_if_c = 1'b1;
            end else begin
                rcnt_nxt = (rcnt != '0) ? rcnt - RCNT_W'(1) : rcnt;
                if (rcnt <= RCNT_W'(1)) state_nxt = RUN;
            end
        end else if (bus.EX_Mispredict) begin
            f_id_c    = 1'b1;
            f_ex_c    = 1'b1;
            rv_c      = 1'b1;
            rcnt_nxt  = RCNT_W'(REDIRECT_CYC - 1);
            state_nxt = (REDIRECT_CYC > 1) ? REDIRECT : RUN;
        end else if (lu_hit_c) begin
            s_if_c = 1'b1;
            s_id_c = 1'b1;
            f_ex_c = 1'b1;
        end else if (bus.IC_Busy) begin
            s_if_c    = 1'b1;
            f_id_c    = 1'b1;
            state_nxt = FETCHWAIT;
        end else begin
            state_nxt = RUN;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state        <= RUN;
            rcnt         <= '0;
            ctx_redirect <= 1'b0;
        end else begin
            state        <= state_nxt;
            rcnt         <= rcnt_nxt;
            ctx_redirect <= ctx_nxt;
        end
    end

    // Control nets are forced quiet while reset is held
    assign bus.STALL_IF       = s_if_c  & ~RESET;
    assign bus.STALL_ID       = s_id_c  & ~RESET;
    assign bus.STALL_EX       = s_ex_c  & ~RESET;
    assign bus.STALL_MEM      = s_mem_c & ~RESET;
    assign bus.FLUSH_ID       = f_id_c  & ~RESET;
    assign bus.FLUSH_EX       = f_ex_c  & ~RESET;
    assign bus.Redirect_Valid = rv_c    & ~RESET;
    assign bus.Ctrl_State     = state;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt, flush_cnt, lu_cnt;
    logic             mp_acc_c, lu_acc_c;

    assign mp_acc_c = ~bus.DC_Busy & (eff_c != REDIRECT) & bus.EX_Mispredict;
    assign lu_acc_c = ~bus.DC_Busy & (eff_c != REDIRECT) & ~bus.EX_Mispredict & lu_hit_c;

    // Saturating event counters
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            lu_cnt    <= '0;
        end else begin
            if (s_if_c   && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (mp_acc_c && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
            if (lu_acc_c && (lu_cnt    != '1)) lu_cnt    <= lu_cnt    + CNT_W'(1);
        end
    end

    assign bus.Stall_Cycles  = stall_cnt;
    assign bus.Flush_Events  = flush_cnt;
    assign bus.LoadUse_Count = lu_cnt;
`else
    assign bus.Stall_Cycles  = CNT_W'(0);
    assign bus.Flush_Events  = CNT_W'(0);
    assign bus.LoadUse_Count = CNT_W'(0);
`endif

endmodule
